taxi_axis_reg_slice: RTL and testbench

TAXI_AXIS_REG_SLICE -- requirements
Module: taxi_axis_reg_slice

---
 rtl/taxi_axis_pkg.sv | 11 +
 rtl/taxi_axis_if.sv | 34 +++
 rtl/taxi_axis_reg_slice.sv | 154 +++++++++++++++
 tb/tb_taxi_axis_reg_slice.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/taxi_axis_pkg.sv
// Shared AXI4-Stream definitions: state encoding used by the register slice.
package taxi_axis_pkg;

    // Occupancy of the slice: nothing held, output register only, output plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } reg_slice_state_t;

endpackage : taxi_axis_pkg

// File: rtl/taxi_axis_if.sv
// AXI4-Stream interface bundle; optional fields carry an enable so sinks can tie them off.
interface taxi_axis_if #(
    parameter int DATA_W  = 8,
    parameter bit KEEP_EN = 1'b1,
    parameter int KEEP_W  = (DATA_W + 7) / 8,
    parameter bit STRB_EN = 1'b0,
    parameter bit LAST_EN = 1'b1,
    parameter bit ID_EN   = 1'b0,
    parameter int ID_W    = 8,
    parameter bit DEST_EN = 1'b0,
    parameter int DEST_W  = 8,
    parameter bit USER_EN = 1'b0,
    parameter int USER_W  = 1
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [KEEP_W-1:0] tstrb;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdest;
    logic [USER_W-1:0] tuser;

    modport src (
        output tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
        input  tready
    );

    modport snk (
        input  tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
        output tready
    );
endinterface : taxi_axis_if

// File: rtl/taxi_axis_reg_slice.sv
// Full-throughput AXI4-Stream register slice (output register + skid register).
// Optional frame counter on m_axis is built when TAXI_AXIS_REG_SLICE_FRAME_CNT_EN is defined.
module taxi_axis_reg_slice
    import taxi_axis_pkg::*;
#(
    parameter int FRAME_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    taxi_axis_if.snk               s_axis,
    taxi_axis_if.src               m_axis
`ifdef TAXI_AXIS_REG_SLICE_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

    localparam int DATA_W  = s_axis.DATA_W;
    localparam int KEEP_W  = s_axis.KEEP_W;
    localparam int ID_W    = s_axis.ID_W;
    localparam int DEST_W  = s_axis.DEST_W;
    localparam int USER_W  = s_axis.USER_W;
    localparam bit KEEP_EN = s_axis.KEEP_EN && m_axis.KEEP_EN;
    localparam bit STRB_EN = s_axis.STRB_EN && m_axis.STRB_EN;
    localparam bit LAST_EN = s_axis.LAST_EN && m_axis.LAST_EN;
    localparam bit ID_EN   = s_axis.ID_EN   && m_axis.ID_EN;
    localparam bit DEST_EN = s_axis.DEST_EN && m_axis.DEST_EN;
    localparam bit USER_EN = s_axis.USER_EN && m_axis.USER_EN;

    if (m_axis.DATA_W != DATA_W) begin : g_err_data_w
        $fatal(0, "taxi_axis_reg_slice: m_axis DATA_W differs from s_axis");
    end
    if (KEEP_EN && (m_axis.KEEP_W != KEEP_W)) begin : g_err_keep_w
        $fatal(0, "taxi_axis_reg_slice: m_axis KEEP_W differs from s_axis");
    end
    if (FRAME_CNT_W < 1) begin : g_err_frame_cnt_w
        $fatal(0, "taxi_axis_reg_slice: FRAME_CNT_W must be at least 1");
    end

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic [KEEP_W-1:0] strb;
        logic              last;
        logic [ID_W-1:0]   id;
        logic [DEST_W-1:0] dest;
        logic [USER_W-1:0] user;
    } beat_t;

    reg_slice_state_t state, state_next;
    logic  s_tready_reg, s_tready_next;
    logic  m_tvalid_reg, m_tvalid_next;
    logic  load_out_s, load_out_skid, load_skid;
    logic  s_accept, m_accept;
    logic  [KEEP_W-1:0] s_keep;
    beat_t s_beat, out_reg, skid_reg;

    // Disabled fields are tied at the input so both registers only ever hold legal values.
    assign s_keep = KEEP_EN ? s_axis.tkeep : '1;
    assign s_beat = '{
        data: s_axis.tdata,
        keep: s_keep,
        strb: STRB_EN ? s_axis.tstrb : s_keep,
        last: LAST_EN ? s_axis.tlast : 1'b1,
        id:   ID_EN   ? s_axis.tid   : '0,
        dest: DEST_EN ? s_axis.tdest : '0,
        user: USER_EN ? s_axis.tuser : '0
    };

    assign s_accept = s_axis.tvalid && s_tready_reg;
    assign m_accept = m_tvalid_reg && m_axis.tready;

    always_comb begin
        // NOTE: every output gets a default first so no branch can leave one unassigned and infer a latch.
        state_next    = state;
        load_out_s    = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        unique case (state)
            EMPTY: begin
                if (s_accept) begin
                    state_next = ONE;
                    load_out_s = 1'b1;
                end
            end
            ONE: begin
                if (s_accept && m_accept) begin
                    load_out_s = 1'b1;
                end else if (s_accept) begin
                    state_next = TWO;
                    load_skid  = 1'b1;
                end else if (m_accept) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (m_accept) begin
                    state_next    = ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        // Handshake flags are registered from the next state, so m tready never reaches s tready.
        s_tready_next = (state_next != TWO);
        m_tvalid_next = (state_next != EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            s_tready_reg <= 1'b0;
            m_tvalid_reg <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            state        <= state_next;
            s_tready_reg <= s_tready_next;
            m_tvalid_reg <= m_tvalid_next;
        end
    end

    // NOTE: payload registers are not reset; the valid flags alone decide whether they hold a beat.
    always_ff @(posedge clk) begin
        if (load_out_s) begin
            out_reg <= s_beat;
        end else if (load_out_skid) begin
            out_reg <= skid_reg;
        end
        if (load_skid) begin
            skid_reg <= s_beat;
        end
    end

    assign s_axis.tready = s_tready_reg;
    assign m_axis.tvalid = m_tvalid_reg;
    assign m_axis.tdata  = out_reg.data;
    assign m_axis.tkeep  = out_reg.keep;
    assign m_axis.tstrb  = out_reg.strb;
    assign m_axis.tlast  = out_reg.last;
    assign m_axis.tid    = out_reg.id;
    assign m_axis.tdest  = out_reg.dest;
    assign m_axis.tuser  = out_reg.user;

`ifdef TAXI_AXIS_REG_SLICE_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (m_accept && out_reg.last) begin
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
        end
    end
`endif

endmodule : taxi_axis_reg_slice

// File: tb/tb_taxi_axis_reg_slice.sv
// Bench for taxi_axis_reg_slice: directed vector table, reset/config sequences, random scoreboard run.
module tb_taxi_axis_reg_slice;

    localparam int N_RANDOM   = 10000;
    localparam int CYCLE_CAP  = 80000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    taxi_axis_if #(.DATA_W(16), .KEEP_EN(1'b1), .KEEP_W(2), .STRB_EN(1'b0), .LAST_EN(1'b1),
                   .ID_EN(1'b1), .ID_W(4), .DEST_EN(1'b0), .DEST_W(3), .USER_EN(1'b1), .USER_W(3))
        s_if(), m_if();

    // Second slice: keep and last disabled on the sink side only.
    taxi_axis_if #(.DATA_W(16), .KEEP_EN(1'b0), .KEEP_W(2), .LAST_EN(1'b0), .ID_EN(1'b1), .ID_W(4),
                   .DEST_W(3), .USER_W(3)) s2_if();
    taxi_axis_if #(.DATA_W(16), .KEEP_EN(1'b1), .KEEP_W(2), .LAST_EN(1'b1), .ID_EN(1'b1), .ID_W(4),
                   .DEST_W(3), .USER_W(3)) m2_if();

`ifdef TAXI_AXIS_REG_SLICE_FRAME_CNT_EN
    logic [3:0] frame_cnt, frame_cnt2;
`endif

    taxi_axis_reg_slice #(.FRAME_CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .s_axis(s_if), .m_axis(m_if)
`ifdef TAXI_AXIS_REG_SLICE_FRAME_CNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    taxi_axis_reg_slice #(.FRAME_CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .s_axis(s2_if), .m_axis(m2_if)
`ifdef TAXI_AXIS_REG_SLICE_FRAME_CNT_EN
        , .frame_cnt(frame_cnt2)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_s(input logic v, input logic [15:0] d, input logic [1:0] k, input logic l,
                           input logic [3:0] id, input logic [2:0] u);
        s_if.tvalid = v;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tstrb  = 2'b00;
        s_if.tlast  = l;
        s_if.tid    = id;
        s_if.tdest  = 3'(id);
        s_if.tuser  = u;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        s_if.tvalid  = 1'b0;
        m_if.tready  = 1'b0;
        s2_if.tvalid = 1'b0;
        m2_if.tready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Directed vectors: inputs for one cycle, outputs expected just after that edge.
    typedef struct {
        logic        s_valid;
        logic [15:0] s_data;
        logic        m_ready;
        logic        exp_m_valid;
        logic [15:0] exp_m_data;
        logic        exp_s_ready;
    } vec_t;

    function automatic vec_t mk_vec(input logic sv, input logic [15:0] sd, input logic mr,
                                    input logic ev, input logic [15:0] ed, input logic er);
        vec_t v;
        v.s_valid = sv; v.s_data = sd; v.m_ready = mr;
        v.exp_m_valid = ev; v.exp_m_data = ed; v.exp_s_ready = er;
        return v;
    endfunction

    // Reference beat as seen at the output: strb follows keep and dest is zero since both are disabled.
    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  keep;
        logic        last;
        logic [3:0]  id;
        logic [2:0]  user;
    } beat_t;

    function automatic beat_t m_beat();
        beat_t b;
        b.data = m_if.tdata; b.keep = m_if.tkeep; b.last = m_if.tlast;
        b.id = m_if.tid; b.user = m_if.tuser;
        return b;
    endfunction

    vec_t  vecs[$];
    beat_t q[$];

    initial begin
        drive_s(1'b0, 16'h0, 2'b11, 1'b1, 4'h0, 3'h0);
        m_if.tready  = 1'b0;
        s2_if.tvalid = 1'b0; s2_if.tdata = '0; s2_if.tkeep = '0; s2_if.tstrb = '0;
        s2_if.tlast  = 1'b0; s2_if.tid = '0; s2_if.tdest = '0; s2_if.tuser = '0;
        m2_if.tready = 1'b0;

        // Back-to-back 0x01..0x08 with the sink always ready, then drain.
        for (int k = 1; k <= 8; k++) vecs.push_back(mk_vec(1'b1, 16'(k), 1'b1, 1'b1, 16'(k), 1'b1));
        vecs.push_back(mk_vec(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1));
        // Three stalled cycles while 0xA, 0xB, 0xC are offered, then release.
        vecs.push_back(mk_vec(1'b1, 16'h000A, 1'b0, 1'b1, 16'h000A, 1'b1));
        vecs.push_back(mk_vec(1'b1, 16'h000B, 1'b0, 1'b1, 16'h000A, 1'b0));
        vecs.push_back(mk_vec(1'b1, 16'h000C, 1'b0, 1'b1, 16'h000A, 1'b0));
        vecs.push_back(mk_vec(1'b1, 16'h000C, 1'b1, 1'b1, 16'h000B, 1'b1));
        vecs.push_back(mk_vec(1'b1, 16'h000C, 1'b1, 1'b1, 16'h000C, 1'b1));
        vecs.push_back(mk_vec(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1));

        // Reset state, checked while reset is still asserted.
        #2;
        check("reset m_tvalid", 32'(m_if.tvalid), 32'd0);
        check("reset s_tready", 32'(s_if.tready), 32'd0);
`ifdef TAXI_AXIS_REG_SLICE_FRAME_CNT_EN
        check("reset frame_cnt", 32'(frame_cnt), 32'd0);
`endif
        step();
        rst_n = 1'b1;
        step();
        check("tready after first edge", 32'(s_if.tready), 32'd1);
        check("tvalid idle after reset", 32'(m_if.tvalid), 32'd0);

        foreach (vecs[i]) begin
            drive_s(vecs[i].s_valid, vecs[i].s_data, 2'b11, 1'b1, 4'h0, 3'h0);
            m_if.tready = vecs[i].m_ready;
            step();
            check($sformatf("vec%0d m_tvalid", i), 32'(m_if.tvalid), 32'(vecs[i].exp_m_valid));
            check($sformatf("vec%0d s_tready", i), 32'(s_if.tready), 32'(vecs[i].exp_s_ready));
            if (vecs[i].exp_m_valid)
                check($sformatf("vec%0d m_tdata", i), 32'(m_if.tdata), 32'(vecs[i].exp_m_data));
        end

        // Keep/last disabled on the sink side: output ties to keep all-ones, strb = keep, last = 1.
        m2_if.tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s2_if.tvalid = 1'b1; s2_if.tdata = 16'(16'h0100 + k);
            s2_if.tkeep = 2'b00; s2_if.tlast = 1'b0;
            step();
            check($sformatf("tie%0d tvalid", k), 32'(m2_if.tvalid), 32'd1);
            check($sformatf("tie%0d tdata", k), 32'(m2_if.tdata), 32'(16'h0100 + k));
            check($sformatf("tie%0d tkeep", k), 32'(m2_if.tkeep), 32'h3);
            check($sformatf("tie%0d tstrb", k), 32'(m2_if.tstrb), 32'h3);
            check($sformatf("tie%0d tlast", k), 32'(m2_if.tlast), 32'd1);
        end
        s2_if.tvalid = 1'b0;
        step();
        check("tie drained", 32'(m2_if.tvalid), 32'd0);

        // Fill both registers, then reset asynchronously in the middle of the cycle.
        m_if.tready = 1'b0;
        drive_s(1'b1, 16'h0011, 2'b11, 1'b1, 4'h0, 3'h0);
        step();
        drive_s(1'b1, 16'h0022, 2'b11, 1'b1, 4'h0, 3'h0);
        step();
        check("full s_tready", 32'(s_if.tready), 32'd0);
        check("full m_tdata", 32'(m_if.tdata), 32'h0011);
        s_if.tvalid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst m_tvalid", 32'(m_if.tvalid), 32'd0);
        check("async rst s_tready", 32'(s_if.tready), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("post rst discarded", 32'(m_if.tvalid), 32'd0);
        m_if.tready = 1'b1;
        drive_s(1'b1, 16'h0055, 2'b11, 1'b1, 4'h0, 3'h0);
        step();
        check("post rst 0x55 valid", 32'(m_if.tvalid), 32'd1);
        check("post rst 0x55 data", 32'(m_if.tdata), 32'h0055);
        s_if.tvalid = 1'b0;
        step();
        check("post rst 0x55 alone", 32'(m_if.tvalid), 32'd0);

`ifdef TAXI_AXIS_REG_SLICE_FRAME_CNT_EN
        // 17 single-beat frames through a 4-bit counter wrap to 1.
        do_reset();
        m_if.tready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            drive_s(1'b1, 16'(k), 2'b11, 1'b1, 4'h0, 3'h0);
            step();
        end
        s_if.tvalid = 1'b0;
        step();
        check("frame_cnt wrap", 32'(frame_cnt), 32'd1);
`endif

        // Random traffic against a queue model holding at most two beats.
        begin
            int    sent = 0, recv = 0, cycles = 0, exp_frames = 0;
            logic  s_acc, m_acc, held;
            beat_t held_beat, nb;
            do_reset();
            q.delete();
            while (recv < N_RANDOM && cycles < CYCLE_CAP) begin
                if (!s_if.tvalid && sent < N_RANDOM && $urandom_range(1) == 1) begin
                    nb = beat_t'($urandom);
                    drive_s(1'b1, nb.data, nb.keep, nb.last, nb.id, nb.user);
                    s_if.tstrb = 2'($urandom);
                    s_if.tdest = 3'($urandom);
                end
                m_if.tready = ($urandom_range(1) == 1);
                s_acc = s_if.tvalid && s_if.tready;
                m_acc = m_if.tvalid && m_if.tready;
                held  = m_if.tvalid && !m_if.tready;
                held_beat = m_beat();
                if (m_acc) begin
                    check("rnd beat expected", 32'(q.size() != 0), 32'd1);
                    if (q.size() != 0) begin
                        check($sformatf("rnd beat %0d", recv), 32'(m_beat()), 32'(q[0]));
                        check("rnd tstrb=tkeep", 32'(m_if.tstrb), 32'(q[0].keep));
                        check("rnd tdest tied", 32'(m_if.tdest), 32'd0);
                        if (q[0].last) exp_frames++;
                        void'(q.pop_front());
                    end
                    recv++;
                end
                if (s_acc) begin
                    nb.data = s_if.tdata; nb.keep = s_if.tkeep; nb.last = s_if.tlast;
                    nb.id = s_if.tid; nb.user = s_if.tuser;
                    q.push_back(nb);
                    sent++;
                end
                step();
                cycles++;
                if (s_acc) s_if.tvalid = 1'b0;
                check("rnd m_tvalid", 32'(m_if.tvalid), 32'(q.size() != 0));
                check("rnd s_tready", 32'(s_if.tready), 32'(q.size() < 2));
                if (held) check("rnd stall stable", 32'(m_beat()), 32'(held_beat));
            end
            check("rnd beats received", 32'(recv), 32'(N_RANDOM));
`ifdef TAXI_AXIS_REG_SLICE_FRAME_CNT_EN
            check("rnd frame_cnt", 32'(frame_cnt), 32'(exp_frames % 16));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_taxi_axis_reg_slice
